// File: rtl/div_sched.sv
// Round-robin front end for the pipelined signed divider: issues one operation per
// cycle and returns each result to its owner by means of a tag line that mirrors the pipeline depth.
module div_sched #(
  parameter int Latency = 18,
  parameter int AnchoDd = 31,
  parameter int AnchoDv = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0In,
  input  logic               req1In,
  input  logic [AnchoDd:0]   dividend0In,
  input  logic [AnchoDd:0]   dividend1In,
  input  logic [AnchoDv:0]   divisor0In,
  input  logic [AnchoDv:0]   divisor1In,
  output logic               ack0Out,
  output logic               ack1Out,
  output logic               goOut,
  output logic [AnchoDd:0]   dividendOut,
  output logic [AnchoDv:0]   divisorOut,
  input  logic               pipeGoIn,
  input  logic [AnchoDv:0]   pipeQuotientIn,
  input  logic [AnchoDv:0]   pipeRemainderIn,
  input  logic               pipeDivisorNoCeroIn,
  output logic               done0Out,
  output logic               done1Out,
  output logic [AnchoDv:0]   quotientOut,
  output logic [AnchoDv:0]   remainderOut,
  output logic               divZeroOut,
  output logic [4:0]         inFlightOut,
  output logic               seqErrOut
);

  logic               rrPtr_q, rrPtr_d;
  logic               go_q, go_d;
  logic               goId_q, goId_d;
  logic [AnchoDd:0]   dividend_q, dividend_d;
  logic [AnchoDv:0]   divisor_q, divisor_d;
  logic [Latency-1:0] tagValid_q, tagValid_d;
  logic [Latency-1:0] tagId_q, tagId_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic [AnchoDv:0]   quotient_q, quotient_d;
  logic [AnchoDv:0]   remainder_q, remainder_d;
  logic               divZero_q, divZero_d;
  logic [4:0]         inFlight_q, inFlight_d;
  logic               seqErr_q, seqErr_d;

  logic grant0, grant1, issue, tailValid, tailId, retire;

  // rrPtr_q high means client 1 wins a tie; a lone requester always wins.
  assign grant0    = req0In & (~req1In | ~rrPtr_q);
  assign grant1    = req1In & ~grant0;
  assign issue     = grant0 | grant1;
  assign tailValid = tagValid_q[Latency-1];
  assign tailId    = tagId_q[Latency-1];
  assign retire    = pipeGoIn & tailValid;

  always_comb begin
    rrPtr_d     = issue ? grant0 : rrPtr_q;
    go_d        = issue;
    goId_d      = issue ? grant1 : goId_q;
    dividend_d  = grant0 ? dividend0In : (grant1 ? dividend1In : dividend_q);
    divisor_d   = grant0 ? divisor0In  : (grant1 ? divisor1In  : divisor_q);
    // The tag enters alongside goOut, so the tail lines up with pipeGoIn.
    tagValid_d  = {tagValid_q[Latency-2:0], go_q};
    tagId_d     = {tagId_q[Latency-2:0], goId_q};
    done0_d     = retire & ~tailId;
    done1_d     = retire & tailId;
    quotient_d  = retire ? pipeQuotientIn  : quotient_q;
    remainder_d = retire ? pipeRemainderIn : remainder_q;
    divZero_d   = retire & ~pipeDivisorNoCeroIn;
    inFlight_d  = inFlight_q + {4'b0, go_q} - {4'b0, tailValid};
    seqErr_d    = seqErr_q | (pipeGoIn ^ tailValid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrPtr_q     <= 1'b0;
      go_q        <= 1'b0;
      goId_q      <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      tagValid_q  <= '0;
      tagId_q     <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divZero_q   <= 1'b0;
      inFlight_q  <= '0;
      seqErr_q    <= 1'b0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      go_q        <= go_d;
      goId_q      <= goId_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      tagValid_q  <= tagValid_d;
      tagId_q     <= tagId_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divZero_q   <= divZero_d;
      inFlight_q  <= inFlight_d;
      seqErr_q    <= seqErr_d;
    end
  end

  assign ack0Out      = grant0;
  assign ack1Out      = grant1;
  assign goOut        = go_q;
  assign dividendOut  = dividend_q;
  assign divisorOut   = divisor_q;
  assign done0Out     = done0_q;
  assign done1Out     = done1_q;
  assign quotientOut  = quotient_q;
  assign remainderOut = remainder_q;
  assign divZeroOut   = divZero_q;
  assign inFlightOut  = inFlight_q;
  assign seqErrOut    = seqErr_q;

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: a stub divider pipeline plus a cycle-indexed reference model
// of arbitration, issue, retirement and in-flight counting.
module tb_div_sched;

  localparam int Lat    = 18;
  localparam int MaxCyc = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0In, req1In;
  logic [31:0] dividend0In, dividend1In;
  logic [15:0] divisor0In, divisor1In;
  logic        ack0Out, ack1Out, goOut;
  logic [31:0] dividendOut;
  logic [15:0] divisorOut;
  logic        pipeGoIn;
  logic [15:0] pipeQuotientIn, pipeRemainderIn;
  logic        pipeDivisorNoCeroIn;
  logic        done0Out, done1Out;
  logic [15:0] quotientOut, remainderOut;
  logic        divZeroOut;
  logic [4:0]  inFlightOut;
  logic        seqErrOut;

  div_sched #(.Latency(Lat), .AnchoDd(31), .AnchoDv(15)) dut (
    .clk(clk), .reset(reset),
    .req0In(req0In), .req1In(req1In),
    .dividend0In(dividend0In), .dividend1In(dividend1In),
    .divisor0In(divisor0In), .divisor1In(divisor1In),
    .ack0Out(ack0Out), .ack1Out(ack1Out), .goOut(goOut),
    .dividendOut(dividendOut), .divisorOut(divisorOut),
    .pipeGoIn(pipeGoIn), .pipeQuotientIn(pipeQuotientIn),
    .pipeRemainderIn(pipeRemainderIn), .pipeDivisorNoCeroIn(pipeDivisorNoCeroIn),
    .done0Out(done0Out), .done1Out(done1Out),
    .quotientOut(quotientOut), .remainderOut(remainderOut),
    .divZeroOut(divZeroOut), .inFlightOut(inFlightOut), .seqErrOut(seqErrOut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int peakInFl = 0;
  bit forceGo = 1'b0;

  // Reference model: pointer, last issue, and per-cycle expectations.
  bit          favour1;
  bit          lastGo;
  logic [31:0] curDd;
  logic [15:0] curDv;
  bit          errSticky;
  bit          expDone0 [MaxCyc];
  bit          expDone1 [MaxCyc];
  logic [15:0] expQ     [MaxCyc];
  logic [15:0] expR     [MaxCyc];
  bit          expDz    [MaxCyc];
  bit          expTail  [MaxCyc];
  int          expInFl  [MaxCyc];

  // Stub pipeline: results scheduled by cycle index.
  bit          stubGo [MaxCyc];
  logic [15:0] stubQ  [MaxCyc];
  logic [15:0] stubR  [MaxCyc];
  bit          stubNz [MaxCyc];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void refDiv(input logic [31:0] dd, input logic [15:0] dv,
                                 output logic [15:0] q, output logic [15:0] r, output bit nz);
    longint a, b;
    a = longint'($signed(dd));
    b = longint'($signed(dv));
    if (b == 0) begin
      q = 16'hFFFF; r = dd[15:0]; nz = 1'b0;
    end else begin
      q = 16'(a / b); r = 16'(a % b); nz = 1'b1;
    end
  endfunction

  task automatic clearModel();
    favour1 = 0; lastGo = 0; curDd = '0; curDv = '0; errSticky = 0;
    for (int i = 0; i < MaxCyc; i++) begin
      expDone0[i] = 0; expDone1[i] = 0; expQ[i] = '0; expR[i] = '0; expDz[i] = 0;
      expTail[i] = 0; expInFl[i] = 0;
      stubGo[i] = 0; stubQ[i] = '0; stubR[i] = '0; stubNz[i] = 0;
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the model.
  task automatic applyStimulus(input bit r0, input bit r1,
                               input logic [31:0] a0, input logic [15:0] b0,
                               input logic [31:0] a1, input logic [15:0] b1);
    bit g0, g1, d0, d1;
    logic [15:0] q, r;
    bit nz;
    req0In = r0; req1In = r1;
    dividend0In = a0; divisor0In = b0;
    dividend1In = a1; divisor1In = b1;
    pipeGoIn = stubGo[cyc] | forceGo;
    pipeQuotientIn = stubQ[cyc];
    pipeRemainderIn = stubR[cyc];
    pipeDivisorNoCeroIn = stubNz[cyc];
    @(negedge clk);
    g0 = r0 && (!r1 || !favour1);
    g1 = r1 && !g0;
    d0 = expDone0[cyc];
    d1 = expDone1[cyc];
    checkOutput("ack0", {31'b0, ack0Out}, {31'b0, g0});
    checkOutput("ack1", {31'b0, ack1Out}, {31'b0, g1});
    checkOutput("go", {31'b0, goOut}, {31'b0, lastGo});
    checkOutput("dividend", dividendOut, curDd);
    checkOutput("divisor", {16'b0, divisorOut}, {16'b0, curDv});
    checkOutput("done0", {31'b0, done0Out}, {31'b0, d0});
    checkOutput("done1", {31'b0, done1Out}, {31'b0, d1});
    if (d0 || d1) begin
      checkOutput("quotient", {16'b0, quotientOut}, {16'b0, expQ[cyc]});
      checkOutput("remainder", {16'b0, remainderOut}, {16'b0, expR[cyc]});
    end
    checkOutput("divZero", {31'b0, divZeroOut}, {31'b0, expDz[cyc]});
    checkOutput("inFlight", {27'b0, inFlightOut}, expInFl[cyc]);
    checkOutput("seqErr", {31'b0, seqErrOut}, {31'b0, errSticky});
    if (int'(inFlightOut) > peakInFl) peakInFl = int'(inFlightOut);
    if (goOut) begin
      refDiv(dividendOut, divisorOut, q, r, nz);
      stubGo[cyc+Lat] = 1; stubQ[cyc+Lat] = q; stubR[cyc+Lat] = r; stubNz[cyc+Lat] = nz;
    end
    if (pipeGoIn != expTail[cyc]) errSticky = 1;
    lastGo = g0 || g1;
    if (g0 || g1) begin
      favour1 = g0;
      curDd = g0 ? a0 : a1;
      curDv = g0 ? b0 : b1;
      refDiv(curDd, curDv, q, r, nz);
      expTail[cyc+1+Lat] = 1;
      if (g0) expDone0[cyc+2+Lat] = 1;
      else    expDone1[cyc+2+Lat] = 1;
      expQ[cyc+2+Lat] = q; expR[cyc+2+Lat] = r; expDz[cyc+2+Lat] = !nz;
      for (int k = cyc + 2; k <= cyc + 1 + Lat; k++) expInFl[k]++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'h0, 16'h0, 32'h0, 16'h0);
  endtask

  task automatic doReset();
    req0In = 0; req1In = 0; pipeGoIn = 0; forceGo = 0;
    reset = 1;
    #1;
    checkOutput("rstGo", {31'b0, goOut}, 32'h0);
    checkOutput("rstDone", {30'b0, done1Out, done0Out}, 32'h0);
    checkOutput("rstInFlight", {27'b0, inFlightOut}, 32'h0);
    checkOutput("rstSeqErr", {31'b0, seqErrOut}, 32'h0);
    checkOutput("rstDividend", dividendOut, 32'h0);
    checkOutput("rstQuotient", {16'b0, quotientOut}, 32'h0);
    clearModel();
    @(posedge clk);
    #1;
    reset = 0;
    cyc++;
  endtask

  initial begin
    reset = 1;
    req0In = 0; req1In = 0;
    dividend0In = '0; dividend1In = '0; divisor0In = '0; divisor1In = '0;
    pipeGoIn = 0; pipeQuotientIn = '0; pipeRemainderIn = '0; pipeDivisorNoCeroIn = 0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    idle(2);

    // Single operation 100/7 from client 0.
    applyStimulus(1, 0, 32'd100, 16'd7, 32'h0, 16'h0);
    idle(Lat + 4);

    // Three issues, then reset while they are in flight.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 32'd40 + 32'(i), 16'd3, 32'h0, 16'h0);
    idle(5);
    doReset();
    idle(Lat + 4);

    // Contention from reset: client 0 first, then client 1.
    applyStimulus(1, 1, -32'sd100, 16'd7, 32'd50, 16'd5);
    applyStimulus(0, 1, 32'h0, 16'h0, 32'd50, 16'd5);
    idle(Lat + 4);

    // Streaming from client 1 alone.
    peakInFl = 0;
    for (int i = 0; i < 25; i++) applyStimulus(0, 1, 32'h0, 16'h0, $urandom, 16'($urandom_range(1, 999)));
    idle(Lat + 4);
    checkOutput("streamPeak", peakInFl, Lat);

    // Divide by zero followed by a normal division.
    applyStimulus(1, 0, 32'd9, 16'd0, 32'h0, 16'h0);
    applyStimulus(1, 0, 32'd9, 16'd3, 32'h0, 16'h0);
    idle(Lat + 4);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom), 1'($urandom),
                    $urandom, ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom),
                    $urandom, ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom));
    end
    idle(Lat + 4);

    // Spurious pipeline valid with an empty tag line.
    forceGo = 1;
    applyStimulus(0, 0, 32'h0, 16'h0, 32'h0, 16'h0);
    forceGo = 0;
    idle(6);
    doReset();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
